// File: rtl/fetch_unit.sv
// Generic synchronous FIFO with flush; the head entry is read combinationally.
// Latency: a pushed entry reaches the head output on the cycle after the push.
// Backpressure: a push while full lands only alongside a pop; a pop while empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_rdy,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             empty, full, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_rdy && !empty;
    assign do_push = push_vld && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;
endmodule

// RV32I fetch stage: owns the PC, issues imem word reads and buffers {pc, word} for the decoder.
// Latency: response to decoder 1 cycle; first redirected request 1 cycle after the last stale response.
// Backpressure: requests need a free slot counting buffered plus in-flight words; decoder stalls hold the FIFO.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic [CW-1:0] fifo_count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nxt;
    logic [CW:0]   credits_used;
    logic          req_fire, rsp_pop, rsp_drop, rsp_keep, instr_pop, fifo_empty;
    logic [31:0]   rsp_addr;
    entry_t        push_entry, head_entry;

    // Buffered words plus in-flight requests never exceed DEPTH, so a response always has a slot.
    assign credits_used   = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req_valid = !reset && (state_q == FETCH) && (credits_used < (CW+1)'(DEPTH));
    assign imem_addr      = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_pop         = imem_rsp_valid && (outstanding != '0);
    assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(rsp_pop);
    assign rsp_drop        = imem_rsp_valid && ((drop_cnt_q != '0) || redirect_valid);
    assign rsp_keep        = imem_rsp_valid && !rsp_drop;

    assign fifo_empty  = (fifo_count == '0);
    assign instr_valid = !reset && !fifo_empty && !redirect_valid;
    assign instr_pop   = instr_valid && instr_ready;
    assign instruction = head_entry.word;
    assign instr_pc    = head_entry.pc;

    assign push_entry.pc   = rsp_addr;
    assign push_entry.word = imem_rsp_data;

    // The address queue's occupancy is the outstanding-request count.
    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_addr_q (
        .clk      (clk),
        .reset    (reset),
        .clear    (1'b0),
        .push_vld (req_fire),
        .push_dat (pc_q),
        .pop_rdy  (imem_rsp_valid),
        .head_dat (rsp_addr),
        .count    (outstanding)
    );

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk      (clk),
        .reset    (reset),
        .clear    (redirect_valid),
        .push_vld (rsp_keep),
        .push_dat (push_entry),
        .pop_rdy  (instr_pop),
        .head_dat (head_entry),
        .count    (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_cnt_d = drop_cnt_q;
        if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end
        if (imem_rsp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end
        if ((state_q == FLUSH) && (drop_cnt_d == '0)) begin
            state_d = FETCH;
        end
        // Every request still in flight after this cycle is stale, including one firing now.
        if (redirect_valid) begin
            pc_d       = redirect_pc & ~32'd3;
            drop_cnt_d = outstanding_nxt;
            state_d    = (outstanding_nxt != '0) ? FLUSH : FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end
endmodule
